// File: rtl/mmio_port_uart_responder.sv
// mmio_port_uart_responder
//
// Memory-mapped I/O responder on the MEM-stage data bus. It provides a 4-register window at
// IO_BASE with a PortOut register, a synchronized PortIn view, and an 8N1 serial transmitter
// that has a one-deep holding buffer and a status register.
//
// Register map (offset from IO_BASE, Address[1:0] ignored):
//   +0  PORT_OUT   read/write, 32 bits
//   +4  PORT_IN    read-only, {24'b0, synchronized PortIn}
//   +8  TX_DATA    write-only, WriteData[7:0] goes to the holding buffer; reads return 0
//   +12 TX_STATUS  read-only {29'b0, ovf, hold_full, busy}; writing 1 to bit 2 clears ovf
//
// Ports:
//   clk        system clock, all state updates on its rising edge
//   reset      synchronous, active-high reset
//   MemWrite   bus write strobe
//   MemRead    bus read strobe
//   Address    byte address
//   WriteData  store data
//   PortIn     asynchronous external input pins
//   ReadData   combinational read data, 0 unless a read hits the window
//   Hit        Address lies inside the window
//   PortOut    PortOut register
//   TxSerial   serial line, idles high

module mmio_port_uart_responder #(
    parameter logic [31:0] IO_BASE      = 32'h1001_0024,
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic [7:0]  PortIn,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic [31:0] PortOut,
    output logic        TxSerial
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e           state_q;
    logic [31:0]      port_out_q;
    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [7:0]       hold_q;
    logic             hold_full_q;
    logic             ovf_q;
    logic [7:0]       shift_q;
    logic [BaudW-1:0] baud_q;
    logic [2:0]       bit_q;
    logic             tx_q;

    // Offset relative to the base; the unsigned wrap makes one compare cover any base.
    logic [31:0] offset;
    logic [1:0]  reg_sel;
    logic        unused_offset;

    assign offset        = Address - IO_BASE;
    assign reg_sel       = offset[3:2];
    assign unused_offset = ^offset[1:0];
    assign Hit           = (offset[31:4] == 28'd0);

    logic wr_en;
    logic port_out_wr;
    logic tx_data_wr;
    logic ovf_clr;
    logic baud_done;
    logic load;
    logic busy;
    logic tx_next;

    assign wr_en       = MemWrite && Hit;
    assign port_out_wr = wr_en && (reg_sel == 2'd0);
    assign tx_data_wr  = wr_en && (reg_sel == 2'd2);
    assign ovf_clr     = wr_en && (reg_sel == 2'd3) && WriteData[2];
    assign baud_done   = (baud_q == BaudLast);
    assign busy        = (state_q != StIdle);

    // The shifter takes the buffer from idle, or at the end of a stop bit for a
    // back-to-back frame.
    assign load = hold_full_q &&
                  ((state_q == StIdle) || ((state_q == StStop) && baud_done));

    // Line level for the current state; registered into tx_q, so the line lags the
    // state by one cycle.
    always_comb begin
        tx_next = 1'b1;
        unique case (state_q)
            StIdle:  tx_next = 1'b1;
            StStart: tx_next = 1'b0;
            StData:  tx_next = shift_q[bit_q];
            StStop:  tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

    always_comb begin
        ReadData = 32'd0;
        if (MemRead && Hit) begin
            unique case (reg_sel)
                2'd0:    ReadData = port_out_q;
                2'd1:    ReadData = {24'd0, sync2_q};
                2'd2:    ReadData = 32'd0;
                2'd3:    ReadData = {29'd0, ovf_q, hold_full_q, busy};
                default: ReadData = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            port_out_q  <= 32'd0;
            sync1_q     <= 8'd0;
            sync2_q     <= 8'd0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            shift_q     <= 8'd0;
            baud_q      <= '0;
            bit_q       <= 3'd0;
            tx_q        <= 1'b1;
        end else begin
            sync1_q <= PortIn;
            sync2_q <= sync1_q;

            if (port_out_wr) begin
                port_out_q <= WriteData;
            end

            // A write on the same edge as a load refills the buffer; otherwise a write
            // to a full buffer is dropped and flagged.
            if (tx_data_wr) begin
                if (!hold_full_q || load) begin
                    hold_q      <= WriteData[7:0];
                    hold_full_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end else if (load) begin
                hold_full_q <= 1'b0;
            end

            if (ovf_clr) begin
                ovf_q <= 1'b0;
            end

            tx_q <= tx_next;

            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        shift_q <= hold_q;
                        baud_q  <= '0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        bit_q   <= 3'd0;
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (load) begin
                            shift_q <= hold_q;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign PortOut  = port_out_q;
    assign TxSerial = tx_q;

endmodule

// File: tb/tb_mmio_port_uart_responder.sv
// Testbench for mmio_port_uart_responder with CLKS_PER_BIT = 4.
// Inputs are driven on the falling clock edge; the serial line is compared every cycle
// against a queue of expected line levels filled when bytes are written.

module tb_mmio_port_uart_responder;

    localparam int unsigned CPB  = 4;
    localparam logic [31:0] BASE = 32'h1001_0024;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        TxSerial;

    int vectors;
    int miscompares;

    logic        exp_q[$];
    logic [31:0] rd_q[$];

    mmio_port_uart_responder #(
        .IO_BASE      (BASE),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .Address   (Address),
        .WriteData (WriteData),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortOut   (PortOut),
        .TxSerial  (TxSerial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic drive_idle();
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Address   = 32'd0;
        WriteData = 32'd0;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        MemRead   = 1'b0;
        Address   = a;
        WriteData = d;
    endtask

    task automatic push_frame(input logic [7:0] b);
        for (int r = 0; r < int'(CPB); r++) exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int r = 0; r < int'(CPB); r++) exp_q.push_back(b[i]);
        end
        for (int r = 0; r < int'(CPB); r++) exp_q.push_back(1'b1);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(1'b1);
    endtask

    // One clock; compare the line against the next expected level.
    task automatic step_tx();
        logic e;
        @(negedge clk);
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL tx_queue_empty: no expected level at time %0t", $time);
        end else begin
            e = exp_q.pop_front();
            if (TxSerial !== e) begin
                miscompares++;
                $display("FAIL tx_serial at %0t: got %b expected %b", $time, TxSerial, e);
            end
        end
    endtask

    task automatic check_read(input logic [31:0] a, input logic [31:0] e, input string name);
        logic [31:0] exp_v;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        Address  = a;
        rd_q.push_back(e);
        #1;
        exp_v = rd_q.pop_front();
        vectors++;
        if (ReadData !== exp_v) begin
            miscompares++;
            $display("FAIL %s: ReadData got %h expected %h", name, ReadData, exp_v);
        end
        drive_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        PortIn = 8'h00;
        repeat (3) @(negedge clk);
        vectors++;
        if (TxSerial !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_tx: got %b expected 1", TxSerial);
        end
        vectors++;
        if (PortOut !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_portout: got %h expected 0", PortOut);
        end
        #1;
        vectors++;
        if (Hit !== 1'b0 || ReadData !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_idle_bus: Hit %b ReadData %h expected 0 0", Hit, ReadData);
        end
        check_read(BASE + 32'd12, 32'd0, "reset_status");
        check_read(BASE + 32'd4, 32'd0, "reset_portin");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_port_out();
        @(negedge clk);
        drive_write(BASE, 32'hDEAD_BEEF);
        @(negedge clk);
        drive_idle();
        vectors++;
        if (PortOut !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL portout_reg: got %h expected deadbeef", PortOut);
        end
        check_read(BASE, 32'hDEAD_BEEF, "portout_read");
        check_read(BASE + 32'd3, 32'hDEAD_BEEF, "portout_lowbits_ignored");
        check_read(BASE + 32'd8, 32'd0, "txdata_reads_zero");
        MemRead = 1'b1;
        Address = BASE + 32'd16;
        #1;
        vectors++;
        if (Hit !== 1'b0 || ReadData !== 32'd0) begin
            miscompares++;
            $display("FAIL above_window: Hit %b ReadData %h expected 0 0", Hit, ReadData);
        end
        Address = BASE - 32'd4;
        #1;
        vectors++;
        if (Hit !== 1'b0 || ReadData !== 32'd0) begin
            miscompares++;
            $display("FAIL below_window: Hit %b ReadData %h expected 0 0", Hit, ReadData);
        end
        drive_idle();
        // Simultaneous read and write: read sees the old value.
        @(negedge clk);
        drive_write(BASE, 32'h1234_5678);
        MemRead = 1'b1;
        #1;
        vectors++;
        if (ReadData !== 32'hDEAD_BEEF || Hit !== 1'b1) begin
            miscompares++;
            $display("FAIL rw_same_cycle: ReadData %h Hit %b expected deadbeef 1", ReadData, Hit);
        end
        @(negedge clk);
        drive_idle();
        vectors++;
        if (PortOut !== 32'h1234_5678) begin
            miscompares++;
            $display("FAIL rw_commit: got %h expected 12345678", PortOut);
        end
    endtask

    task automatic test_port_in();
        logic [7:0] vals[2];
        logic [7:0] old_v;
        vals[0] = 8'hA5;
        vals[1] = 8'h3C;
        old_v   = 8'h00;
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            PortIn = vals[v];
            for (int k = 0; k < 4; k++) begin
                if (k > 0) @(negedge clk);
                check_read(BASE + 32'd4, {24'd0, (k >= 2) ? vals[v] : old_v}, "portin_sync");
            end
            old_v = vals[v];
        end
    endtask

    task automatic test_tx_frame();
        @(negedge clk);
        drive_write(BASE + 32'd8, 32'h0000_0053);
        push_idle(2);
        push_frame(8'h53);
        step_tx();
        drive_idle();
        check_read(BASE + 32'd12, 32'h2, "status_after_write");
        step_tx();
        check_read(BASE + 32'd12, 32'h1, "status_start");
        for (int i = 0; exp_q.size() > 0; i++) begin
            step_tx();
            if (i == 20) check_read(BASE + 32'd12, 32'h1, "status_busy_mid");
        end
        check_read(BASE + 32'd12, 32'h0, "status_after_frame");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_write(BASE + 32'd8, 32'h0000_0001);
        push_idle(2);
        push_frame(8'h01);
        step_tx();
        drive_write(BASE + 32'd8, 32'h0000_0002);
        push_frame(8'h02);
        step_tx();
        drive_idle();
        for (int i = 0; exp_q.size() > 0; i++) begin
            step_tx();
            if (i == 10) check_read(BASE + 32'd12, 32'h3, "b2b_status_held");
        end
        check_read(BASE + 32'd12, 32'h0, "b2b_status_end");
    endtask

    task automatic test_overflow();
        @(negedge clk);
        drive_write(BASE + 32'd8, 32'h0000_0011);
        push_idle(2);
        push_frame(8'h11);
        step_tx();
        drive_write(BASE + 32'd8, 32'h0000_0022);
        push_frame(8'h22);
        step_tx();
        drive_idle();
        repeat (3) step_tx();
        drive_write(BASE + 32'd8, 32'h0000_00FF);
        step_tx();
        drive_idle();
        check_read(BASE + 32'd12, 32'h7, "ovf_set");
        while (exp_q.size() > 0) step_tx();
        push_idle(12);
        while (exp_q.size() > 0) step_tx();
        check_read(BASE + 32'd12, 32'h4, "ovf_sticky");
        drive_write(BASE + 32'd12, 32'h0000_0004);
        push_idle(1);
        step_tx();
        drive_idle();
        check_read(BASE + 32'd12, 32'h0, "ovf_cleared");
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        drive_write(BASE + 32'd8, 32'h0000_005A);
        push_idle(2);
        push_frame(8'h5A);
        step_tx();
        drive_idle();
        repeat (18) step_tx();
        exp_q.delete();
        reset = 1'b1;
        drive_write(BASE, 32'hFFFF_FFFF);
        push_idle(1);
        step_tx();
        reset = 1'b0;
        drive_idle();
        vectors++;
        if (PortOut !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_portout: got %h expected 0", PortOut);
        end
        check_read(BASE + 32'd12, 32'h0, "reset_mid_status");
        check_read(BASE, 32'h0, "reset_mid_portout_read");
        drive_write(BASE + 32'd8, 32'h0000_00C3);
        push_idle(2);
        push_frame(8'hC3);
        step_tx();
        drive_idle();
        while (exp_q.size() > 0) step_tx();
        check_read(BASE + 32'd12, 32'h0, "post_reset_frame_status");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        PortIn      = 8'h00;
        drive_idle();
        test_reset();
        test_port_out();
        test_port_in();
        test_tx_frame();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
